// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU driver and its bench.
// State encoding, ALU op codes and the default operand width.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NOTA = 2'd3;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_alu_driver_if.sv
// Request/status and 1-bit ALU signals of the serial driver, bundled in one interface.
// master = driver side; slave = tile pins plus the ALU slice.
interface serial_alu_driver_if
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [1:0]       alu_ctrl;
  logic             alu_in_1;
  logic             alu_in_2;
  logic             alu_data_out;

  modport master (
    input  start, op, opa, opb, alu_data_out,
    output busy, done, result, zero, alu_ctrl, alu_in_1, alu_in_2
  );

  modport slave (
    output start, op, opa, opb, alu_data_out,
    input  busy, done, result, zero, alu_ctrl, alu_in_1, alu_in_2
  );

endinterface

// File: rtl/serial_alu_shifter.sv
// Operand shift registers, result accumulator and bit counter for the serial driver.
// Load takes priority over shift; the counter saturates at WIDTH-1 on the last sample.
module serial_alu_shifter
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             bit_i,
  output logic             a_lsb_o,
  output logic             b_lsb_o,
  output logic [WIDTH-1:0] acc_o,
  output logic             last_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o  = (cnt_q == CNT_W'(WIDTH - 1));
  assign a_lsb_o = sha_q[0];
  assign b_lsb_o = shb_q[0];
  assign acc_o   = acc_q;

  always_comb begin
    sha_d = sha_q;
    shb_d = shb_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sha_d = opa_i;
      shb_d = opb_i;
      cnt_d = '0;
    end else if (shift_i) begin
      // Operands drain to zero after WIDTH shifts, so the ALU inputs idle low.
      sha_d = sha_q >> 1;
      shb_d = shb_q >> 1;
      acc_d = {bit_i, acc_q[WIDTH-1:1]};
      if (!last_o) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha_q <= '0;
      shb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      sha_q <= sha_d;
      shb_q <= shb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_alu_driver.sv
// Bit-serial driver for a 1-bit ALU slice: LSB-first operand bits, word result and zero flag.
// Registered status: done WIDTH+2 cycles after start; start is ignored while busy (no queue).
module serial_alu_driver
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_alu_driver_if.master bus
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             load;
  logic             shift;
  logic             last;
  logic             a_lsb;
  logic             b_lsb;
  logic [WIDTH-1:0] acc;

  serial_alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .shift_i (shift),
    .opa_i   (bus.opa),
    .opb_i   (bus.opb),
    .bit_i   (bus.alu_data_out),
    .a_lsb_o (a_lsb),
    .b_lsb_o (b_lsb),
    .acc_o   (acc),
    .last_o  (last)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    load     = 1'b0;
    shift    = 1'b0;
    busy_d   = (state_q != ST_IDLE);
    done_d   = (state_q == ST_DONE);
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          op_d    = bus.op;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        shift = 1'b1;
        if (last) begin
          // Op register doubles as alu_ctrl, so clearing it idles the ALU control at 0.
          op_d    = 2'b00;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = acc;
        zero_d   = (acc == '0);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  assign bus.alu_ctrl = op_q;
  assign bus.alu_in_1 = a_lsb;
  assign bus.alu_in_2 = b_lsb;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_serial_alu_driver.sv
// Randomized and directed bench for serial_alu_driver (WIDTH=8 and WIDTH=2 builds).
// Word-level reference model; a combinational 1-bit ALU model closes the loop.
module tb_serial_alu_driver;
  import serial_alu_pkg::*;

  localparam int W  = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_alu_driver_if #(.WIDTH(W))  bus  ();
  serial_alu_driver_if #(.WIDTH(W2)) bus2 ();

  serial_alu_driver #(.WIDTH(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_alu_driver #(.WIDTH(W2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  function automatic logic alu_bit(input logic [1:0] c, input logic a, input logic b);
    case (c)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~a;
    endcase
  endfunction

  assign bus.alu_data_out  = alu_bit(bus.alu_ctrl,  bus.alu_in_1,  bus.alu_in_2);
  assign bus2.alu_data_out = alu_bit(bus2.alu_ctrl, bus2.alu_in_1, bus2.alu_in_2);

  function automatic logic [15:0] ref_word(input logic [1:0] o, input logic [15:0] a,
                                           input logic [15:0] b, input int w);
    logic [15:0] r;
    logic [15:0] mask;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    mask = 16'((32'd1 << w) - 32'd1);
    return r & mask;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit stray);
    logic [15:0]  r16;
    logic [W-1:0] exp_r;
    logic [W-1:0] s1, s2, res, held_r;
    logic         z, held_z;
    int           ctrl_bad, done_at, ndone;
    r16      = ref_word(o, 16'(a), 16'(b), W);
    exp_r    = r16[W-1:0];
    s1       = '0;
    s2       = '0;
    res      = '0;
    held_r   = '0;
    z        = 1'b0;
    held_z   = 1'b0;
    ctrl_bad = 0;
    done_at  = -1;
    ndone    = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      if (i <= W) begin
        s1[i-1] = bus.alu_in_1;
        s2[i-1] = bus.alu_in_2;
        if (bus.alu_ctrl !== o) ctrl_bad++;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = i;
          res     = bus.result;
          z       = bus.zero;
        end
      end
      if (i == W + 3) begin
        held_r = bus.result;
        held_z = bus.zero;
      end
      if (i == 1) begin
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.opa   = W'($urandom);
        bus.opb   = W'($urandom);
      end
      if (stray && i == 3) begin
        bus.start = 1'b1;
        bus.opa   = '1;
      end
      if (stray && i == 4) bus.start = 1'b0;
    end
    check({tag, ".in1_seq"},  32'(s1), 32'(a));
    check({tag, ".in2_seq"},  32'(s2), 32'(b));
    check({tag, ".ctrl_run"}, 32'(ctrl_bad), 32'd0);
    check({tag, ".done_lat"}, 32'(done_at), 32'(W + 2));
    check({tag, ".done_cnt"}, 32'(ndone), 32'd1);
    check({tag, ".result"},   32'(res), 32'(exp_r));
    check({tag, ".zero"},     32'(z), 32'(exp_r == '0));
    check({tag, ".res_hold"}, 32'(held_r), 32'(exp_r));
    check({tag, ".z_hold"},   32'(held_z), 32'(exp_r == '0));
  endtask

  task automatic run_op2(input string tag, input logic [1:0] o, input logic [W2-1:0] a,
                         input logic [W2-1:0] b);
    logic [15:0]   r16;
    logic [W2-1:0] exp_r, res;
    logic          z;
    int            done_at;
    r16     = ref_word(o, 16'(a), 16'(b), W2);
    exp_r   = r16[W2-1:0];
    res     = '0;
    z       = 1'b0;
    done_at = -1;
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.op    = o;
    bus2.opa   = a;
    bus2.opb   = b;
    for (int i = 1; i <= W2 + 4; i++) begin
      @(negedge clk);
      if (bus2.done === 1'b1 && done_at < 0) begin
        done_at = i;
        res     = bus2.result;
        z       = bus2.zero;
      end
      if (i == 1) bus2.start = 1'b0;
    end
    check({tag, ".done_lat"}, 32'(done_at), 32'(W2 + 2));
    check({tag, ".result"},   32'(res), 32'(exp_r));
    check({tag, ".zero"},     32'(z), 32'(exp_r == '0));
  endtask

  initial begin
    int nd;
    int prev;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.opa    = '0;
    bus.opb    = '0;
    bus2.start = 1'b0;
    bus2.op    = 2'b00;
    bus2.opa   = '0;
    bus2.opb   = '0;
    #1;
    check("reset.outputs", 32'({bus.busy, bus.done, bus.result, bus.zero,
                                bus.alu_ctrl, bus.alu_in_1, bus.alu_in_2}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("and", OP_AND, 8'hF0, 8'h3C, 1'b0);

    // Abort mid-operation; the previous result is non-zero so the clear is visible.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_OR;
    bus.opa   = 8'hFF;
    bus.opb   = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.pre_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.async", 32'({bus.busy, bus.done, bus.result, bus.zero,
                            bus.alu_ctrl, bus.alu_in_1, bus.alu_in_2}), 32'd0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    check("rst.no_done", 32'(nd), 32'd0);
    run_op("post_rst", OP_XOR, 8'h3C, 8'h0F, 1'b0);

    run_op("xor_zero", OP_XOR, 8'hA5, 8'hA5, 1'b0);
    run_op("busy_rej", OP_OR, 8'h01, 8'h80, 1'b1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_NOTA;
    bus.opa   = 8'h0F;
    bus.opb   = W'($urandom);
    nd   = 0;
    prev = 0;
    for (int i = 1; i <= 3 * (W + 2) + 1; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        check("b2b.result",    32'(bus.result), 32'h0000_00F0);
        check("b2b.idle_ctrl", 32'(bus.alu_ctrl), 32'd0);
        if (prev > 0) check("b2b.gap", 32'(i - prev), 32'(W + 2));
        else          check("b2b.first", 32'(i), 32'(W + 2));
        prev = i;
      end
    end
    check("b2b.count", 32'(nd), 32'd3);
    bus.start = 1'b0;
    repeat (W + 4) @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      run_op("rand", 2'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    run_op2("w2_or", OP_OR, 2'b01, 2'b10);
    for (int k = 0; k < 4; k++) begin
      run_op2("w2_rand", 2'($urandom), W2'($urandom), W2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
